// File: rtl/ssd_bcd_driver.sv
// ssd_bcd_driver: multi-digit seven-segment display driver.
// Accepts a signed/unsigned integer over valid/ready. An iterative double-dabble
// engine converts it to BCD. The result is formatted with sign, overflow dashes
// and optional leading-zero blanking, then time-multiplexed onto one segment bus.
// Build option: define SSD_LZB_EN for leading-zero blanking with a floating sign.
module ssd_bcd_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int IN_WIDTH   = 16,
    parameter int DIV_BITS   = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_signed,
    output logic [6:0]            seg_a,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL  = pow10(NUM_DIGITS) - 64'd1;
    localparam logic [63:0] NMAX_VAL = pow10(NUM_DIGITS - 1) - 64'd1;

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3f;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5b;
            4'd3:    s = 7'h4f;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6d;
            4'd6:    s = 7'h7d;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7f;
            4'd9:    s = 7'h6f;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t                           state_q, state_d;
    logic [IN_WIDTH-1:0]              mag_q, mag_d;
    logic                             neg_q, neg_d;
    logic                             ovf_q, ovf_d;
    logic [BCD_W-1:0]                 bcd_q, bcd_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][6:0]       disp_q, disp_d;
    logic [DIV_BITS-1:0]              div_q, div_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;

    logic                             cap_neg;
    logic [IN_WIDTH-1:0]              cap_mag;
    logic [BCD_W-1:0]                 bcd_adj;
    logic [NUM_DIGITS-1:0][6:0]       fmt;

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            div_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
        end
    end

    // Input capture: magnitude, sign flag and range check on the accepted value.
    always_comb begin
        cap_neg = in_signed && in_data[IN_WIDTH-1];
        cap_mag = cap_neg ? -in_data : in_data;
    end

    // Double-dabble add-3 correction on every BCD nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display formatting from the finished BCD: numerals, sign, blanking, overflow.
    always_comb begin
        int unsigned msd;
        msd = 0;
        fmt = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
`ifdef SSD_LZB_EN
            if (i > msd) begin
                fmt[i] = SEG_BLANK;
            end else begin
                fmt[i] = seg_of(bcd_q[4*i +: 4]);
            end
            if (neg_q && (i == msd + 1)) begin
                fmt[i] = SEG_DASH;
            end
`else
            fmt[i] = seg_of(bcd_q[4*i +: 4]);
            if (neg_q && (i == NUM_DIGITS - 1)) begin
                fmt[i] = SEG_DASH;
            end
`endif
            if (ovf_q) begin
                fmt[i] = SEG_DASH;
            end
        end
    end

    // Conversion FSM: IDLE accepts, CONV shifts IN_WIDTH bits, COMMIT loads display.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mag_d   = cap_mag;
                    neg_d   = cap_neg;
                    ovf_d   = cap_neg ? (64'(cap_mag) > NMAX_VAL)
                                      : (64'(cap_mag) > MAX_VAL);
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, mag_q[IN_WIDTH-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d  = fmt;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Free-running refresh divider; digit index advances when it wraps.
    always_comb begin
        div_d = div_q + DIV_BITS'(1);
        idx_d = idx_q;
        if (div_q == '1) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Outputs decoded purely from registers.
    always_comb begin
        in_ready       = (state_q == S_IDLE);
        dig_sel        = '0;
        dig_sel[idx_q] = 1'b1;
        seg_a          = disp_q[idx_q];
    end

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Directed bench for ssd_bcd_driver (NUM_DIGITS=4, IN_WIDTH=16, DIV_BITS=4).
// Expected displays follow SSD_LZB_EN when it is defined for the build.
module tb_ssd_bcd_driver;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_signed;
    logic [6:0]  seg_a;
    logic [3:0]  dig_sel;

    int total;
    int bad;
    logic [27:0] cur_disp;
    logic [27:0] got;
    logic [27:0] exp5;
    int          low;

    ssd_bcd_driver #(
        .NUM_DIGITS(4),
        .IN_WIDTH  (16),
        .DIV_BITS  (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_signed(in_signed),
        .seg_a    (seg_a),
        .dig_sel  (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dig_of(input logic [27:0] d, input logic [3:0] sel);
        case (sel)
            4'b0001: return d[6:0];
            4'b0010: return d[13:7];
            4'b0100: return d[20:14];
            4'b1000: return d[27:21];
            default: return 7'h7f;
        endcase
    endfunction

    // Collect one full scan of the display as {d3,d2,d1,d0}.
    task automatic read_disp(output logic [27:0] d);
        logic [3:0] seen;
        seen = '0;
        d    = '0;
        for (int c = 0; c < 100 && seen != 4'hf; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (dig_sel == (4'b0001 << i)) begin
                    d[7*i +: 7] = seg_a;
                    seen[i]     = 1'b1;
                end
            end
        end
        chk("scan_cover", {28'd0, seen}, 32'hf);
    endtask

    task automatic send(input string tag, input logic [15:0] d, input logic s,
                        input logic [27:0] expd);
        logic [6:0] last_seg;
        logic [3:0] last_sel;
        logic [27:0] rd;
        last_seg  = 7'h7f;
        last_sel  = 4'b0000;
        in_data   = d;
        in_signed = s;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        low = 0;
        while (!in_ready && low < 100) begin
            last_seg = seg_a;
            last_sel = dig_sel;
            low++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy"}, low, 17);
        chk({tag, "_old"}, {25'd0, last_seg}, {25'd0, dig_of(cur_disp, last_sel)});
        chk({tag, "_new"}, {25'd0, seg_a}, {25'd0, dig_of(expd, dig_sel)});
        cur_disp = expd;
        read_disp(rd);
        chk({tag, "_disp"}, {4'd0, rd}, {4'd0, expd});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cur_disp  = '0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_seg", {25'd0, seg_a}, 32'h00);
        chk("rst_sel", {28'd0, dig_sel}, 32'h1);
        chk("rst_rdy", {31'd0, in_ready}, 32'h1);

        // Scan steps once every 16 clocks after reset release.
        for (int s = 0; s < 4; s++) begin
            repeat (15) @(posedge clk);
            #1;
            chk("scan_hold", {28'd0, dig_sel}, 32'(4'b0001 << s));
            @(posedge clk); #1;
            chk("scan_step", {28'd0, dig_sel}, 32'(4'b0001 << ((s + 1) % 4)));
        end

        send("u1234", 16'd1234, 1'b0, {7'h06, 7'h5b, 7'h4f, 7'h66});
`ifdef SSD_LZB_EN
        send("s_m45", 16'hFFD3, 1'b1, {7'h00, 7'h40, 7'h66, 7'h6d});
`else
        send("s_m45", 16'hFFD3, 1'b1, {7'h40, 7'h3f, 7'h66, 7'h6d});
`endif
        send("u65491", 16'hFFD3, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40});
        send("u9999", 16'd9999, 1'b0, {7'h6f, 7'h6f, 7'h6f, 7'h6f});
        send("u10000", 16'd10000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40});
        send("s_m1000", 16'hFC18, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40});
        send("s_m999", 16'hFC19, 1'b1, {7'h40, 7'h6f, 7'h6f, 7'h6f});
        send("s_8000", 16'h8000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40});
`ifdef SSD_LZB_EN
        send("u7", 16'd7, 1'b0, {7'h00, 7'h00, 7'h00, 7'h07});
        send("u0", 16'd0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3f});
        exp5 = {7'h00, 7'h00, 7'h00, 7'h6d};
`else
        send("u7", 16'd7, 1'b0, {7'h3f, 7'h3f, 7'h3f, 7'h07});
        send("u0", 16'd0, 1'b0, {7'h3f, 7'h3f, 7'h3f, 7'h3f});
        exp5 = {7'h3f, 7'h3f, 7'h3f, 7'h6d};
`endif

        // Back-to-back: hold in_valid with 5 then 6.
        in_data   = 16'd5;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_data = 16'd6;
        low = 0;
        while (!in_ready && low < 100) begin
            low++;
            @(posedge clk); #1;
        end
        chk("b2b_busy5", low, 17);
        chk("b2b_show5", {25'd0, seg_a}, {25'd0, dig_of(exp5, dig_sel)});
        @(posedge clk); #1;
        chk("b2b_accept6", {31'd0, in_ready}, 32'h0);
        in_valid = 1'b0;
        cur_disp = exp5;

        // Reset eight cycles into the conversion of 6.
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst2_rdy", {31'd0, in_ready}, 32'h1);
        chk("rst2_seg", {25'd0, seg_a}, 32'h00);
        chk("rst2_sel", {28'd0, dig_sel}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("rst2_idle", {31'd0, in_ready}, 32'h1);
        read_disp(got);
        chk("rst2_no6", {4'd0, got}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
